// File: rtl/poly_pmul_ctrl_if.sv
// Bus between the pointwise-multiply sequencer and its coefficient memories,
// the K-2RED reducer and the result memory.
interface poly_pmul_ctrl_if #(
    parameter int AW = 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [11:0]   a_rdata;
    logic [11:0]   b_rdata;
    logic [23:0]   prod;
    logic [11:0]   red_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    // The sequencer is the bus master: it owns addresses, product and writes.
    modport master (
        input  start, a_rdata, b_rdata, red_in,
        output busy, done, rd_addr, prod, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, a_rdata, b_rdata, red_in,
        input  busy, done, rd_addr, prod, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_pmul_ctrl.sv
// Kyber pointwise multiply sequencer: streams a*b into the 2-cycle K-2RED
// reducer and writes each reduced coefficient back, one coefficient per clock.
module poly_pmul_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input logic              clk,
    input logic              rst,
    poly_pmul_ctrl_if.master bus_if
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam int            DLY       = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            issue_vld_q, issue_vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [23:0]     prod_q, prod_d;
    logic [DLY-1:0]  dly_vld_q, dly_vld_d;
    logic [AW-1:0]   dly_addr_q [DLY];
    logic [AW-1:0]   dly_addr_d [DLY];
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [11:0]     wr_data_q, wr_data_d;
    logic            drained;

    // Pass is finished only once nothing is in flight and the final write has retired.
    assign drained = !issue_vld_q && (dly_vld_q == '0) && !wr_en_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_vld_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    state_d     = RUN;
                    rd_addr_d   = '0;
                    issue_vld_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    rd_addr_d   = rd_addr_q + 1'b1;
                    issue_vld_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Delay line stage k holds the read issued k+1 cycles ago; its tail meets red_in.
    always_comb begin
        prod_d = prod_q;
        if (state_q != IDLE) begin
            prod_d = 24'(bus_if.a_rdata) * 24'(bus_if.b_rdata);
        end
        dly_vld_d     = {dly_vld_q[DLY-2:0], issue_vld_q};
        dly_addr_d[0] = rd_addr_q;
        for (int i = 1; i < DLY; i++) begin
            dly_addr_d[i] = dly_addr_q[i-1];
        end
        wr_en_d   = dly_vld_q[DLY-1];
        wr_addr_d = dly_addr_q[DLY-1];
        wr_data_d = bus_if.red_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            issue_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prod_q      <= '0;
            dly_vld_q   <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_addr_q[i] <= '0;
            end
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issue_vld_q <= issue_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            prod_q      <= prod_d;
            dly_vld_q   <= dly_vld_d;
            for (int i = 0; i < DLY; i++) begin
                dly_addr_q[i] <= dly_addr_d[i];
            end
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus_if.busy    = busy_q;
    assign bus_if.done    = done_q;
    assign bus_if.rd_addr = rd_addr_q;
    assign bus_if.prod    = prod_q;
    assign bus_if.wr_en   = wr_en_q;
    assign bus_if.wr_addr = wr_addr_q;
    assign bus_if.wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_pmul_ctrl.sv
// Bench for poly_pmul_ctrl: models the coefficient memories and the 2-cycle
// K-2RED reducer, and checks every write against 169*a*b mod 3329.
module tb_poly_pmul_ctrl;
    localparam int N  = 256;
    localparam int AW = 8;
    localparam int Q  = 3329;

    logic clk = 1'b0;
    logic rst = 1'b0;

    poly_pmul_ctrl_if #(.AW(AW)) bus ();

    poly_pmul_ctrl #(.N(N), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] memA [N];
    logic [11:0] memB [N];
    logic [11:0] aRd      = '0;
    logic [11:0] bRd      = '0;
    logic [11:0] redStage = '0;
    logic [11:0] redOut   = '0;

    // Synchronous-read memories and a reducer that keeps its pipeline through rst.
    always @(posedge clk) begin
        aRd      <= memA[bus.rd_addr];
        bRd      <= memB[bus.rd_addr];
        redStage <= 12'((longint'(bus.prod) * 64'd169) % 64'd3329);
        redOut   <= redStage;
    end

    assign bus.a_rdata = aRd;
    assign bus.b_rdata = bRd;
    assign bus.red_in  = redOut;

    int total = 0;
    int bad   = 0;
    int cycleCnt = 0;
    int wrCount, orderBad, doneCount, doneAt, busyCnt;
    int wrHits [N];
    logic [11:0] wrLog [N];
    logic [23:0] prodLog [N];
    bit prodSeen [N];
    logic [AW-1:0] hist1, hist2;
    bit busyH1, busyH2;

    function automatic logic [11:0] golden(input logic [11:0] a, input logic [11:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return 12'((p * 169) % Q);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        wrCount = 0; orderBad = 0; doneCount = 0; doneAt = 0; busyCnt = 0;
        hist1 = '0; hist2 = '0; busyH1 = 1'b0; busyH2 = 1'b0;
        for (int i = 0; i < N; i++) begin
            wrHits[i] = 0; wrLog[i] = '0; prodLog[i] = '0; prodSeen[i] = 1'b0;
        end
    endtask

    // One clock: sample everything at the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
        cycleCnt++;
        if (busyH2 && !prodSeen[hist2]) begin
            prodLog[hist2]  = bus.prod;
            prodSeen[hist2] = 1'b1;
        end
        hist2 = hist1; busyH2 = busyH1;
        hist1 = bus.rd_addr; busyH1 = bus.busy;
        if (bus.busy === 1'b1) busyCnt++;
        if (bus.wr_en === 1'b1) begin
            if (bus.wr_addr !== AW'(wrCount)) orderBad++;
            wrHits[bus.wr_addr]++;
            wrLog[bus.wr_addr] = bus.wr_data;
            wrCount++;
        end
        if (bus.done === 1'b1) begin
            doneCount++;
            doneAt = cycleCnt;
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < N; i++) begin
            memA[i] = 12'($urandom_range(0, Q - 1));
            memB[i] = 12'($urandom_range(0, Q - 1));
        end
    endtask

    task automatic applyStimulus(input bit pokes);
        int startCyc;
        int guard;
        int hitBad;
        clearLog();
        startCyc  = cycleCnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (doneCount == 0 && guard < 400) begin
            if (pokes && guard == 50) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            guard++;
        end
        checkOutput("done_seen", 32'(doneCount > 0), 32'd1);
        checkOutput("done_cycle", doneAt - startCyc, 263);
        if (pokes) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        repeat (12) tick();
        checkOutput("done_count", doneCount, 1);
        checkOutput("busy_cycles", busyCnt, 262);
        checkOutput("busy_after", bus.busy, 0);
        checkOutput("wr_count", wrCount, N);
        checkOutput("wr_order", orderBad, 0);
        hitBad = 0;
        for (int i = 0; i < N; i++) if (wrHits[i] != 1) hitBad++;
        checkOutput("wr_hits", hitBad, 0);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("prod[%0d]", i), prodLog[i], 24'(memA[i]) * 24'(memB[i]));
            checkOutput($sformatf("wr_data[%0d]", i), wrLog[i], golden(memA[i], memB[i]));
        end
    endtask

    initial begin
        int guard;
        bus.start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            memA[i] = '0; memB[i] = '0;
        end
        clearLog();
        repeat (3) tick();
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_rd_addr", bus.rd_addr, 0);
        checkOutput("rst_prod", bus.prod, 0);
        checkOutput("rst_wr_en", bus.wr_en, 0);
        checkOutput("rst_wr_addr", bus.wr_addr, 0);
        checkOutput("rst_wr_data", bus.wr_data, 0);
        rst = 1'b0;

        $display("[TB] idle for 20 cycles");
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("idle_busy", bus.busy, 0);
            checkOutput("idle_done", bus.done, 0);
            checkOutput("idle_wr_en", bus.wr_en, 0);
            checkOutput("idle_prod", bus.prod, 0);
        end

        $display("[TB] all-ones pass");
        for (int i = 0; i < N; i++) begin
            memA[i] = 12'd1; memB[i] = 12'd1;
        end
        applyStimulus(1'b0);
        checkOutput("ones_wr0", wrLog[0], 169);
        checkOutput("ones_wr255", wrLog[255], 169);

        $display("[TB] extreme operands at address 7");
        fillRandom();
        memA[7] = 12'd3328; memB[7] = 12'd3328;
        applyStimulus(1'b0);
        checkOutput("extreme_prod7", prodLog[7], 11075584);
        checkOutput("extreme_wr7", wrLog[7], 169);

        $display("[TB] random pass with start pokes in RUN and DONE");
        fillRandom();
        applyStimulus(1'b1);

        $display("[TB] reset at rd_addr=100");
        fillRandom();
        clearLog();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (bus.rd_addr !== 8'd100 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("reach_addr100", bus.rd_addr, 100);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_done", bus.done, 0);
        checkOutput("mid_rst_rd_addr", bus.rd_addr, 0);
        checkOutput("mid_rst_prod", bus.prod, 0);
        checkOutput("mid_rst_wr_en", bus.wr_en, 0);
        checkOutput("mid_rst_wr_addr", bus.wr_addr, 0);
        checkOutput("mid_rst_wr_data", bus.wr_data, 0);
        tick();
        tick();
        rst = 1'b0;
        clearLog();
        repeat (20) tick();
        checkOutput("post_rst_writes", wrCount, 0);
        checkOutput("post_rst_busy", bus.busy, 0);
        checkOutput("post_rst_done", doneCount, 0);

        $display("[TB] clean pass after reset");
        fillRandom();
        applyStimulus(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_pmul_ctrl.md
# poly_pmul_ctrl

Sequencer for Kyber pointwise coefficient multiplication, directly upstream of the K-2RED two-stage reducer. It reads coefficient pairs from two synchronous-read coefficient memories and forms the 24-bit product. It drives that product into the reducer, captures the reduced 12-bit result on the reducer's output, and writes it back to a result memory at the matching address. It hides the reducer's fixed 2-cycle pipeline behind a valid/address delay line, so one coefficient is processed per clock.

## Interface
- N, 256, coefficients per polynomial; power of two.
- AW, 8, address width; log2(N).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one N-coefficient pass; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final write
- rd_addr  out  AW  shared read address for memories A and B (registered)
- a_rdata  in  12  memory A data, valid the cycle after rd_addr
- b_rdata  in  12  memory B data, valid the cycle after rd_addr
- prod  out  24  registered a*b, drives reducer input
- red_in  in  12  reducer result, valid 2 cycles after prod
- wr_en  out  1  result-memory write strobe (registered)
- wr_addr  out  AW  result address (registered)
- wr_data  out  12  result data (registered copy of red_in)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1, go to RUN, set rd_addr=0, set issue-valid=1, set busy=1.
- RUN: each cycle, rd_addr increments. When rd_addr=N-1 is issued, the next state is DRAIN and issue-valid drops.
- DRAIN: waits until the delay line is empty and the last write has been performed, then goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then back to IDLE.
- start while not IDLE is ignored. start in the DONE cycle is also ignored.
- Product: prod <= a_rdata*b_rdata as an unsigned 12x12 multiply into a full 24 bits with no truncation. It loads every cycle and holds its last value when idle.
- Delay line: a valid bit plus address, 4 stages deep, aligns each read with its result.
- Write: wr_en/wr_addr/wr_data load from the delay-line tail and red_in each cycle. wr_en=0 whenever the tail is not valid.
- The block does not scale inputs or correct the result. With the reducer attached, wr_data ≡ 169·a·b mod 3329. Pre-scaling the operands by 169^-1 is the caller's job.
- rd_addr wraps from N-1 to 0 only via a new start. It never wraps inside a pass.

## Timing
- Cycle 0 is the first cycle rd_addr=i is presented.
- Cycle 1: a/b_rdata[i] valid. Cycle 2: prod(i) valid. Cycle 4: red_in(i) valid.
- Cycle 5: wr_en=1, wr_addr=i, wr_data=red_in(i). Latency from issue to write is 5 cycles.
- Throughput: 1 coefficient/clock. A pass spans N+5 cycles from the first issue to the last write; done follows the cycle after the last write.
- From the start edge to done: N+7 cycles.
- Reset values: busy=0, done=0, rd_addr=0, prod=0, wr_en=0, wr_addr=0, wr_data=0, all delay-line valids=0, state=IDLE.
- Reset mid-pass: everything clears immediately. No further wr_en is produced for that pass, even though the reducer still holds in-flight data.
- Back-to-back passes: a start is accepted earliest in the IDLE cycle after DONE. There is no overlap between passes.

## Test plan
- Reset then idle: no start for 20 cycles -> busy=0, done=0, wr_en=0, prod=0 throughout.
- All-ones pass with the reducer attached: A=B=1 for all 256 coefficients -> 256 writes, wr_data=169 at addresses 0..255 in order, done exactly once at start+263.
- Extreme operands: a[7]=3328, b[7]=3328 -> prod=11075584 two cycles after rd_addr=7; the write to address 7 equals (169·3328·3328) mod 3329 = 169.
- Random vectors: a, b uniform in 0..3328 -> every wr_data equals the golden 169·a·b mod 3329, with no missing or duplicate addresses.
- start asserted during RUN and during DONE -> ignored; only one pass of writes occurs.
- rst asserted at the cycle rd_addr=100 -> all outputs are 0 next cycle, no writes afterwards; a following start runs a clean full pass from address 0.
